// File: rtl/encoder_emulator_pkg.sv
// encoder_pkg: shared constants and the direction type for the encoder
// emulator (period timer, channel generator and its bus interface).
package encoder_pkg;

    // Default datapath width for period and position.
    localparam int ENC_WIDTH        = 32;
    // Interval loaded at reset (0x72F1 clk cycles).
    localparam int ENC_RESET_PERIOD = 29425;
    // Smallest interval the timer will ever run; it guarantees a midpoint.
    localparam int ENC_MIN_PERIOD   = 2;

    // Rotation direction as carried on the dir input.
    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_REV = 1'b1
    } enc_dir_t;

endpackage

// File: rtl/encoder_emulator_if.sv
// encoder_emulator_if: command/status bundle between a speed-loop driver
// (master) and the encoder emulator (slave).
interface encoder_emulator_if
    import encoder_pkg::*;
#(
    parameter int WIDTH = ENC_WIDTH
);
    logic                    enable;
    logic                    dir;
    logic [WIDTH-1:0]        period_in;
    logic                    period_load;
    logic                    period_ack;
    logic                    enc_a;
    logic                    enc_b;
    logic                    edge_strobe;
    logic signed [WIDTH-1:0] position;

    modport master (
        output enable, dir, period_in, period_load,
        input  period_ack, enc_a, enc_b, edge_strobe, position
    );

    modport slave (
        input  enable, dir, period_in, period_load,
        output period_ack, enc_a, enc_b, edge_strobe, position
    );
endinterface

// File: rtl/encoder_emulator_step_timer.sv
// step_timer: interval counter running 1..P with an active and a pending
// period register. Flags the step boundary (count == P) and, when the
// ENCODER_EMULATOR_QUAD_EN build is selected, the midpoint (count == P>>1).
// A pending interval is adopted at a boundary and acknowledged one cycle later.
module step_timer
    import encoder_pkg::*;
#(
    parameter int WIDTH        = ENC_WIDTH,
    parameter int RESET_PERIOD = ENC_RESET_PERIOD,
    parameter int MIN_PERIOD   = ENC_MIN_PERIOD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             period_load,
    input  logic [WIDTH-1:0] period_in,
    output logic             boundary,
`ifdef ENCODER_EMULATOR_QUAD_EN
    output logic             midpoint,
`endif
    output logic             ack
);

    localparam logic [WIDTH-1:0] RESET_P = WIDTH'(RESET_PERIOD);
    localparam logic [WIDTH-1:0] MIN_P   = WIDTH'(MIN_PERIOD);

    // Raise any requested interval to the minimum supported one.
    function automatic logic [WIDTH-1:0] clamp_period(input logic [WIDTH-1:0] p);
        if (p < MIN_P) begin
            return MIN_P;
        end else begin
            return p;
        end
    endfunction

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] active_r;
    logic [WIDTH-1:0] pending_r;
    logic             pending_valid_r;
    logic             ack_r;

    assign boundary = enable && (count_r == active_r);
`ifdef ENCODER_EMULATOR_QUAD_EN
    assign midpoint = enable && (count_r == (active_r >> 1));
`endif
    assign ack      = ack_r;

    // Interval counter: advances only while enabled, wraps to 1 at the boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= WIDTH'(1);
        end else if (boundary) begin
            count_r <= WIDTH'(1);
        end else if (enable) begin
            count_r <= count_r + WIDTH'(1);
        end
    end

    // Period registers: adopt pending at a boundary; a same-cycle load refills pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_r        <= RESET_P;
            pending_r       <= '0;
            pending_valid_r <= 1'b0;
            ack_r           <= 1'b0;
        end else begin
            ack_r <= 1'b0;
            if (boundary && pending_valid_r) begin
                active_r        <= pending_r;
                pending_valid_r <= 1'b0;
                ack_r           <= 1'b1;
            end
            if (period_load) begin
                pending_r       <= clamp_period(period_in);
                pending_valid_r <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/encoder_emulator.sv
// encoder_emulator: synthetic motor encoder. The toggle interval of enc_a
// equals the active period in clk cycles. Define ENCODER_EMULATOR_QUAD_EN
// to add the quadrature channel enc_b; otherwise enc_b is tied low and
// position counts enc_a edges only, with dir selecting the count sign.
module encoder_emulator
    import encoder_pkg::*;
#(
    parameter int WIDTH        = ENC_WIDTH,
    parameter int RESET_PERIOD = ENC_RESET_PERIOD,
    parameter int MIN_PERIOD   = ENC_MIN_PERIOD
) (
    input logic               clk,
    input logic               reset,
    encoder_emulator_if.slave bus
);

    logic             boundary_s;
    logic             ack_s;
    enc_dir_t         dir_r;
    enc_dir_t         step_dir_s;
    logic             toggle_a_s;
    logic             toggle_b_s;
    logic             edge_s;
    logic [WIDTH-1:0] delta_s;
    logic             enc_a_r;
    logic             strobe_r;
    logic [WIDTH-1:0] position_r;
`ifdef ENCODER_EMULATOR_QUAD_EN
    logic             midpoint_s;
    logic             enc_b_r;
`endif

    step_timer #(
        .WIDTH        (WIDTH),
        .RESET_PERIOD (RESET_PERIOD),
        .MIN_PERIOD   (MIN_PERIOD)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .enable      (bus.enable),
        .period_load (bus.period_load),
        .period_in   (bus.period_in),
        .boundary    (boundary_s),
`ifdef ENCODER_EMULATOR_QUAD_EN
        .midpoint    (midpoint_s),
`endif
        .ack         (ack_s)
    );

    // Decide which channel toggles this cycle and the sign of the position step.
    // At a boundary A==B always holds, so a direction change there continues
    // the Gray sequence cleanly; a midpoint only completes a half-step (A!=B).
    always_comb begin
        step_dir_s = dir_r;
        toggle_a_s = 1'b0;
        toggle_b_s = 1'b0;
        if (boundary_s) begin
            step_dir_s = enc_dir_t'(bus.dir);
        end else begin
            step_dir_s = dir_r;
        end
`ifdef ENCODER_EMULATOR_QUAD_EN
        if (boundary_s) begin
            if (step_dir_s == DIR_FWD) begin
                toggle_a_s = 1'b1;
            end else begin
                toggle_b_s = 1'b1;
            end
        end else if (midpoint_s && (enc_a_r != enc_b_r)) begin
            if (dir_r == DIR_FWD) begin
                toggle_b_s = 1'b1;
            end else begin
                toggle_a_s = 1'b1;
            end
        end else begin
            toggle_a_s = 1'b0;
            toggle_b_s = 1'b0;
        end
`else
        toggle_a_s = boundary_s;
        toggle_b_s = 1'b0;
`endif
        edge_s = toggle_a_s | toggle_b_s;
        if (step_dir_s == DIR_REV) begin
            delta_s = {WIDTH{1'b1}};
        end else begin
            delta_s = WIDTH'(1);
        end
    end

    // Direction latch: updated only when a step boundary is taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir_r <= DIR_FWD;
        end else if (boundary_s) begin
            dir_r <= step_dir_s;
        end
    end

    // Registered channel outputs, edge strobe and wrapping position count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enc_a_r    <= 1'b0;
            strobe_r   <= 1'b0;
            position_r <= '0;
        end else begin
            strobe_r <= edge_s;
            if (toggle_a_s) begin
                enc_a_r <= ~enc_a_r;
            end
            if (edge_s) begin
                position_r <= position_r + delta_s;
            end
        end
    end

`ifdef ENCODER_EMULATOR_QUAD_EN
    // Quadrature channel register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enc_b_r <= 1'b0;
        end else if (toggle_b_s) begin
            enc_b_r <= ~enc_b_r;
        end
    end

    assign bus.enc_b = enc_b_r;
`else
    assign bus.enc_b = 1'b0;
`endif

    assign bus.enc_a       = enc_a_r;
    assign bus.edge_strobe = strobe_r;
    assign bus.position    = position_r;
    assign bus.period_ack  = ack_s;

endmodule
